// File: rtl/aim65_kbd_pkg.sv
// Shared types, scancode constants and the PS/2 set-2 to AIM65 matrix map.
package aim65_kbd_pkg;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    localparam logic [7:0] SC_EXT = 8'hE0;
    localparam logic [7:0] SC_BRK = 8'hF0;
    localparam logic [7:0] SC_BAT = 8'hAA;

    // Returns {valid, row[2:0], col[2:0]}; unlisted codes are invalid.
    function automatic logic [6:0] kbd_map(input logic ext, input logic [7:0] code);
        logic [6:0] ent;
        ent = '0;
        if (!ext) begin
            case (code)
                8'h76:   ent = {1'b1, 3'd0, 3'd0};
                8'h5A:   ent = {1'b1, 3'd0, 3'd1};
                8'h29:   ent = {1'b1, 3'd0, 3'd3};
                8'h14:   ent = {1'b1, 3'd0, 3'd4};
                8'h59:   ent = {1'b1, 3'd0, 3'd6};
                8'h12:   ent = {1'b1, 3'd0, 3'd7};
                8'h1E:   ent = {1'b1, 3'd1, 3'd5};
                8'h16:   ent = {1'b1, 3'd1, 3'd6};
                8'h24:   ent = {1'b1, 3'd2, 3'd4};
                8'h1D:   ent = {1'b1, 3'd2, 3'd5};
                8'h15:   ent = {1'b1, 3'd2, 3'd6};
                8'h2B:   ent = {1'b1, 3'd3, 3'd3};
                8'h23:   ent = {1'b1, 3'd3, 3'd4};
                8'h1B:   ent = {1'b1, 3'd3, 3'd5};
                8'h1C:   ent = {1'b1, 3'd3, 3'd6};
                default: ent = '0;
            endcase
        end else begin
            case (code)
                8'h5A:   ent = {1'b1, 3'd0, 3'd1};
                default: ent = '0;
            endcase
        end
        return ent;
    endfunction

endpackage

// File: rtl/aim65_ps2_keymatrix_if.sv
// PS/2 lines in, PIA column drive in, row sense and key event status out.
interface aim65_ps2_keymatrix_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] col_sel;
    logic [7:0] row_out;
    logic       key_strobe;
    logic [7:0] key_code;
    logic       key_break;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data, col_sel,
        input  row_out, key_strobe, key_code, key_break, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data, col_sel,
        output row_out, key_strobe, key_code, key_break, frame_err
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, ps2_clk glitch filter, frame FSM and timeout.
module ps2_rx
    import aim65_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    rx_state_e     state_q, state_d;
    logic          fall, data_bit, tmo_hit, par_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_data_i};
        end
    end

    // filt_cnt_q counts consecutive samples disagreeing with the filtered level.
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_sync_q[1] == filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q     <= clk_sync_q[1];
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + 1'b1;
        end
    end

    assign fall     = filt_q && !clk_sync_q[1] && (filt_cnt_q == FW'(FILTER_LEN - 1));
    assign data_bit = dat_sync_q[1];
    assign tmo_hit  = (state_q != StIdle) && !fall && (tmo_q == TW'(TIMEOUT - 1));
    assign par_ok   = ^{shift_q, par_q};
    assign byte_o   = shift_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = StIdle;
        end else if (fall) begin
            unique case (state_q)
                StIdle:   state_d = data_bit ? StIdle : StData;
                StData:   state_d = (bit_cnt_q == 3'd7) ? StParity : StData;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        byte_valid_o = 1'b0;
        frame_err_o  = 1'b0;
        if (tmo_hit) begin
            frame_err_o = 1'b1;
        end else if (fall) begin
            if (state_q == StIdle) begin
                frame_err_o = data_bit;
            end else if (state_q == StStop) begin
                byte_valid_o = data_bit && par_ok;
                frame_err_o  = !(data_bit && par_ok);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_q     <= 1'b0;
            tmo_q     <= '0;
        end else begin
            if (state_q == StIdle || fall) tmo_q <= '0;
            else                           tmo_q <= tmo_q + 1'b1;
            if (fall) begin
                if (state_q == StIdle) begin
                    bit_cnt_q <= '0;
                end else if (state_q == StData) begin
                    shift_q   <= {data_bit, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end else if (state_q == StParity) begin
                    par_q <= data_bit;
                end
            end
        end
    end

endmodule

// File: rtl/aim65_ps2_keymatrix.sv
// PS/2 keyboard to AIM65 8x8 matrix: prefix decode, key-down map and row sense mux.
module aim65_ps2_keymatrix
    import aim65_kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input logic                  clk,
    input logic                  reset,
    aim65_ps2_keymatrix_if.slave bus
);
    logic [7:0]      rx_byte;
    logic            rx_valid, rx_err;
    logic [7:0][7:0] key_q, key_d;
    logic            ext_q, ext_d, brk_q, brk_d;
    logic            strobe_q, strobe_d, kbrk_q, kbrk_d, err_q;
    logic [7:0]      code_q, code_d, row_q, row_d;
    logic [6:0]      map_ent;

    ps2_rx #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .ps2_clk_i   (bus.ps2_clk),
        .ps2_data_i  (bus.ps2_data),
        .byte_o      (rx_byte),
        .byte_valid_o(rx_valid),
        .frame_err_o (rx_err)
    );

    assign map_ent = kbd_map(ext_q, rx_byte);

    always_comb begin
        key_d    = key_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        strobe_d = 1'b0;
        code_d   = code_q;
        kbrk_d   = kbrk_q;
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_byte == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == SC_BRK) begin
                brk_d = 1'b1;
            end else if (rx_byte == SC_BAT && !ext_q && !brk_q) begin
                key_d = '0;
            end else begin
                if (map_ent[6]) key_d[map_ent[5:3]][map_ent[2:0]] = !brk_q;
                strobe_d = 1'b1;
                code_d   = rx_byte;
                kbrk_d   = brk_q;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end
    end

    // Built from key_d so a map update and a col_sel change land together.
    always_comb begin
        row_d = '1;
        for (int r = 0; r < 8; r++) begin
            row_d[r] = ~|(key_d[r] & ~bus.col_sel);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_q    <= '0;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            strobe_q <= 1'b0;
            code_q   <= '0;
            kbrk_q   <= 1'b0;
            err_q    <= 1'b0;
            row_q    <= 8'hFF;
        end else begin
            key_q    <= key_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            strobe_q <= strobe_d;
            code_q   <= code_d;
            kbrk_q   <= kbrk_d;
            err_q    <= rx_err;
            row_q    <= row_d;
        end
    end

    assign bus.row_out    = row_q;
    assign bus.key_strobe = strobe_q;
    assign bus.key_code   = code_q;
    assign bus.key_break  = kbrk_q;
    assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_aim65_ps2_keymatrix.sv
// Directed bench: PS/2 frames in, key events and matrix row sense checked against hand values.
module tb_aim65_ps2_keymatrix;
    localparam int unsigned TMO  = 1000;
    localparam int unsigned HALF = 20;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   n_strobe = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    aim65_ps2_keymatrix_if bus ();

    aim65_ps2_keymatrix #(
        .FILTER_LEN(8),
        .TIMEOUT   (TMO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always @(negedge clk) begin
        if (bus.key_strobe === 1'b1) n_strobe++;
        if (bus.frame_err === 1'b1) n_err++;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = bits[i];
            cycles(HALF);
            bus.ps2_clk = 1'b0;
            cycles(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        cycles(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic p;
        p = ~^b ^ bad_par;
        send_bits({1'b1, p, b, 1'b0}, 11);
    endtask

    task automatic test_reset;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        bus.col_sel = 8'h00;
        reset = 1'b1;
        cycles(5);
        vectors++;
        if (bus.row_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_row: got %h want ff", bus.row_out);
        end
        vectors++;
        if ({bus.key_strobe, bus.key_break, bus.frame_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000",
                     {bus.key_strobe, bus.key_break, bus.frame_err});
        end
        vectors++;
        if (bus.key_code !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_code: got %h want 00", bus.key_code);
        end
        reset = 1'b0;
        cycles(2);
    endtask

    task automatic test_make;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
        bus.col_sel = 8'hFF;
        send_byte(8'h1C, 1'b0);
        vectors++;
        if (n_strobe - s0 != 1) begin
            miscompares++;
            $display("FAIL make_strobes: got %0d want 1", n_strobe - s0);
        end
        vectors++;
        if (bus.key_code !== 8'h1C || bus.key_break !== 1'b0) begin
            miscompares++;
            $display("FAIL make_event: got code %h brk %b want 1c 0", bus.key_code, bus.key_break);
        end
        vectors++;
        if (n_err != e0) begin
            miscompares++;
            $display("FAIL make_err: got %0d want 0", n_err - e0);
        end
        bus.col_sel = 8'hBF;
        vectors++;
        if (bus.row_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL make_row_latency: got %h want ff", bus.row_out);
        end
        cycles(1);
        vectors++;
        if (bus.row_out !== 8'hF7) begin
            miscompares++;
            $display("FAIL make_row: got %h want f7", bus.row_out);
        end
    endtask

    task automatic test_break;
        int s0;
        s0 = n_strobe;
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b0);
        vectors++;
        if (n_strobe - s0 != 1) begin
            miscompares++;
            $display("FAIL break_strobes: got %0d want 1", n_strobe - s0);
        end
        vectors++;
        if (bus.key_code !== 8'h1C || bus.key_break !== 1'b1) begin
            miscompares++;
            $display("FAIL break_event: got code %h brk %b want 1c 1", bus.key_code, bus.key_break);
        end
        vectors++;
        if (bus.row_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL break_row: got %h want ff", bus.row_out);
        end
    endtask

    task automatic test_errors;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
        send_byte(8'h1C, 1'b1);
        vectors++;
        if (n_err - e0 != 1) begin
            miscompares++;
            $display("FAIL parity_err: got %0d want 1", n_err - e0);
        end
        vectors++;
        if (bus.row_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL parity_row: got %h want ff", bus.row_out);
        end
        send_bits(11'h7FF, 1);
        vectors++;
        if (n_err - e0 != 2) begin
            miscompares++;
            $display("FAIL start_err: got %0d want 2", n_err - e0);
        end
        vectors++;
        if (n_strobe != s0) begin
            miscompares++;
            $display("FAIL err_strobes: got %0d want 0", n_strobe - s0);
        end
    endtask

    task automatic test_multi;
        int s0;
        s0 = n_strobe;
        send_byte(8'h1C, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'h12, 1'b0);
        vectors++;
        if (n_strobe - s0 != 3) begin
            miscompares++;
            $display("FAIL multi_strobes: got %0d want 3", n_strobe - s0);
        end
        bus.col_sel = 8'h00;
        cycles(1);
        vectors++;
        if (bus.row_out !== 8'hF6) begin
            miscompares++;
            $display("FAIL multi_row_all: got %h want f6", bus.row_out);
        end
        bus.col_sel = 8'hFD;
        cycles(1);
        vectors++;
        if (bus.row_out !== 8'hFE) begin
            miscompares++;
            $display("FAIL multi_row_col1: got %h want fe", bus.row_out);
        end
        bus.col_sel = 8'h00;
        cycles(1);
    endtask

    task automatic test_ext_unmapped;
        int s0;
        s0 = n_strobe;
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        vectors++;
        if (n_strobe - s0 != 1 || bus.key_code !== 8'h75 || bus.key_break !== 1'b0) begin
            miscompares++;
            $display("FAIL ext_event: got n %0d code %h brk %b want 1 75 0",
                     n_strobe - s0, bus.key_code, bus.key_break);
        end
        vectors++;
        if (bus.row_out !== 8'hF6) begin
            miscompares++;
            $display("FAIL ext_row: got %h want f6", bus.row_out);
        end
    endtask

    task automatic test_timeout;
        int s0, e0;
        s0 = n_strobe;
        e0 = n_err;
        send_bits(11'b000_0001_0100, 5);
        cycles(TMO + 10);
        vectors++;
        if (n_err - e0 != 1 || n_strobe != s0) begin
            miscompares++;
            $display("FAIL timeout_err: got err %0d strobe %0d want 1 0", n_err - e0, n_strobe - s0);
        end
        send_byte(8'h5A, 1'b0);
        vectors++;
        if (n_strobe - s0 != 1 || bus.key_code !== 8'h5A || bus.key_break !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_recover: got n %0d code %h brk %b want 1 5a 0",
                     n_strobe - s0, bus.key_code, bus.key_break);
        end
    endtask

    task automatic test_bat;
        int s0;
        s0 = n_strobe;
        send_byte(8'hAA, 1'b0);
        vectors++;
        if (n_strobe != s0 || bus.key_code !== 8'h5A) begin
            miscompares++;
            $display("FAIL bat_event: got n %0d code %h want 0 5a", n_strobe - s0, bus.key_code);
        end
        vectors++;
        if (bus.row_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL bat_row: got %h want ff", bus.row_out);
        end
    endtask

    task automatic test_reset_mid;
        int s0, e0;
        send_byte(8'h1C, 1'b0);
        vectors++;
        if (bus.row_out !== 8'hF7) begin
            miscompares++;
            $display("FAIL midrst_pre_row: got %h want f7", bus.row_out);
        end
        send_bits(11'b000_0000_1010, 4);
        s0 = n_strobe;
        e0 = n_err;
        reset = 1'b1;
        cycles(2);
        vectors++;
        if (bus.row_out !== 8'hFF || bus.key_code !== 8'h00 ||
            {bus.key_strobe, bus.key_break, bus.frame_err} !== 3'b000) begin
            miscompares++;
            $display("FAIL midrst_outputs: got row %h code %h flags %b want ff 00 000", bus.row_out,
                     bus.key_code, {bus.key_strobe, bus.key_break, bus.frame_err});
        end
        reset = 1'b0;
        cycles(TMO + 10);
        vectors++;
        if (n_strobe != s0 || n_err != e0 || bus.row_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL midrst_after: got strobe %0d err %0d row %h want 0 0 ff",
                     n_strobe - s0, n_err - e0, bus.row_out);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_errors();
        test_multi();
        test_ext_unmapped();
        test_timeout();
        test_bat();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
